fxp_ema_signal_engine: RTL and testbench

//   Multi-channel fixed-point EMA signal engine: per input price sample, updates N_CH EMAs
//   (one alpha shift each), forms weighted sum signal = sum(w_i*ema_i), checks |signal| vs limit.

---
 rtl/fxp_ema_signal_engine_pkg.sv | 50 +++++
 rtl/fxp_ema_signal_engine_if.sv | 33 +++
 rtl/fxp_ema_signal_engine_ema_step.sv | 29 ++
 rtl/fxp_ema_signal_engine.sv | 201 ++++++++++++++++++++
 tb/tb_fxp_ema_signal_engine.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fxp_ema_signal_engine_pkg.sv
// -----------------------------------------------------------------------------
// fxp_ema_signal_engine_pkg
//   Shared types and fixed-point helpers for the multi-channel EMA signal engine.
//   - engine_state_e : engine FSM states
//   - DEF_SHIFT_*    : default alpha shift of channel 0 and per-channel increment
//   - fxp_mul_shift  : signed multiply with an arithmetic right shift
//   - fxp_sat        : symmetric saturation to a signed width
//   Both helpers work on a wide (128-bit) signed carrier so they serve any
//   operand width up to 64 bits. Callers size-cast the result back down.
// -----------------------------------------------------------------------------
package fxp_ema_signal_engine_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPDATE = 2'd1,
        DONE   = 2'd2
    } engine_state_e;

    localparam int DEF_SHIFT_BASE = 5;
    localparam int DEF_SHIFT_STEP = 2;

    // Full-precision signed product, then drop 'frac' fractional bits with
    // an arithmetic shift (rounds toward minus infinity).
    function automatic logic signed [127:0] fxp_mul_shift(
        input logic signed [63:0] a,
        input logic signed [63:0] b,
        input int                 frac
    );
        logic signed [127:0] p;
        p = 128'(a) * 128'(b);
        return p >>> frac;
    endfunction

    // Clamp to [-(2^(width-1)-1), 2^(width-1)-1]. The most negative code is
    // excluded so that taking the magnitude of the result can never overflow.
    function automatic logic signed [127:0] fxp_sat(
        input logic signed [127:0] acc,
        input int                  width
    );
        logic signed [127:0] maxv;
        maxv = (128'sd1 <<< (width - 1)) - 128'sd1;
        if (acc > maxv) begin
            return maxv;
        end else if (acc < -maxv) begin
            return -maxv;
        end
        return acc;
    endfunction

endpackage

// File: rtl/fxp_ema_signal_engine_if.sv
// -----------------------------------------------------------------------------
// fxp_ema_signal_engine_if
//   Sample-in / result-out bundle of the EMA signal engine.
//   master : upstream sample source + downstream result consumer
//   slave  : the engine
//   in_valid/in_ready  sample handshake, with in_sample, w_flat, limit
//   out_valid/out_ready result handshake, with out_signal, out_over, out_warm
// -----------------------------------------------------------------------------
interface fxp_ema_signal_engine_if #(
    parameter int WIDTH = 32,
    parameter int N_CH  = 2
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [WIDTH-1:0]  in_sample;
    logic [N_CH*WIDTH-1:0]    w_flat;
    logic signed [WIDTH-1:0]  limit;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [WIDTH-1:0]  out_signal;
    logic                     out_over;
    logic                     out_warm;

    modport master (
        output in_valid, in_sample, w_flat, limit, out_ready,
        input  in_ready, out_valid, out_signal, out_over, out_warm
    );

    modport slave (
        input  in_valid, in_sample, w_flat, limit, out_ready,
        output in_ready, out_valid, out_signal, out_over, out_warm
    );
endinterface

// File: rtl/fxp_ema_signal_engine_ema_step.sv
// -----------------------------------------------------------------------------
// fxp_ema_signal_engine_ema_step
//   Combinational EMA update: ema_next = ema + (x - ema) >>> shift.
//   Ports: ema (current EMA), x (new sample), shift (alpha = 2^-shift),
//          ema_next (updated EMA).
//   The difference is formed one bit wider so x - ema cannot wrap; the
//   result always lies between ema and x, so it fits back into WIDTH.
// -----------------------------------------------------------------------------
module fxp_ema_signal_engine_ema_step #(
    parameter int WIDTH = 32
) (
    input  logic signed [WIDTH-1:0] ema,
    input  logic signed [WIDTH-1:0] x,
    input  logic [7:0]              shift,
    output logic signed [WIDTH-1:0] ema_next
);
    logic signed [WIDTH:0] ema_x;
    logic signed [WIDTH:0] x_x;
    logic signed [WIDTH:0] diff;
    logic signed [WIDTH:0] step;

    always_comb begin
        ema_x    = (WIDTH+1)'(ema);
        x_x      = (WIDTH+1)'(x);
        diff     = x_x - ema_x;
        step     = diff >>> shift;
        ema_next = WIDTH'(ema_x + step);
    end
endmodule

// File: rtl/fxp_ema_signal_engine.sv
// -----------------------------------------------------------------------------
// fxp_ema_signal_engine
//   Multi-channel fixed-point EMA signal engine. Each accepted sample updates
//   N_CH EMAs (channel i uses alpha = 2^-(SHIFT_BASE + i*SHIFT_STEP)), one
//   channel per cycle through a shared EMA step unit, and accumulates
//   signal = sum(w_i * ema_i). The saturated signal is compared against a
//   runtime limit and a sticky risk flag is maintained.
//   Ports:
//     clk, rst_n  clock, synchronous active-low reset
//     risk_clr    clears risk_trip (a simultaneous new trip wins)
//     risk_trip   sticky OR of out_over
//     bus         slave side of fxp_ema_signal_engine_if (sample in, result out)
// -----------------------------------------------------------------------------
module fxp_ema_signal_engine
    import fxp_ema_signal_engine_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int FRAC         = 16,
    parameter int N_CH         = 2,
    parameter int SHIFT_BASE   = DEF_SHIFT_BASE,
    parameter int SHIFT_STEP   = DEF_SHIFT_STEP,
    parameter int WARM_SAMPLES = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    risk_clr,
    output logic                    risk_trip,
    fxp_ema_signal_engine_if.slave  bus
);
    localparam int ACC_W = 2*WIDTH + 4;
    localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int CNT_W = $clog2(WARM_SAMPLES + 1);

    engine_state_e state_q, state_d;

    logic [IDX_W-1:0]         idx_q, idx_d;
    logic signed [WIDTH-1:0]  ema_q [N_CH];
    logic signed [WIDTH-1:0]  ema_d [N_CH];
    logic signed [WIDTH-1:0]  w_q   [N_CH];
    logic signed [WIDTH-1:0]  w_d   [N_CH];
    logic signed [WIDTH-1:0]  x_q, x_d;
    logic signed [WIDTH-1:0]  limit_q, limit_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic                     seeded_q, seeded_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic signed [WIDTH-1:0]  out_signal_q, out_signal_d;
    logic                     out_over_q, out_over_d;
    logic                     out_warm_q, out_warm_d;
    logic                     risk_trip_q, risk_trip_d;

    // Per-channel operand selection for the shared step / MAC.
    logic signed [WIDTH-1:0]  ema_sel;
    logic signed [WIDTH-1:0]  w_sel;
    logic [7:0]               shift_sel;
    logic signed [WIDTH-1:0]  ema_stepped;
    logic signed [WIDTH-1:0]  ema_new;
    logic signed [ACC_W-1:0]  acc_next;
    logic signed [WIDTH-1:0]  sat_w;
    logic signed [WIDTH-1:0]  mag;
    logic signed [WIDTH-1:0]  lim_eff;
    logic                     over;
    logic                     last_ch;

    fxp_ema_signal_engine_ema_step #(.WIDTH(WIDTH)) u_ema_step (
        .ema      (ema_sel),
        .x        (x_q),
        .shift    (shift_sel),
        .ema_next (ema_stepped)
    );

    // Shared datapath for the channel selected by idx_q.
    always_comb begin
        ema_sel   = ema_q[idx_q];
        w_sel     = w_q[idx_q];
        shift_sel = 8'(SHIFT_BASE + int'(idx_q) * SHIFT_STEP);
        last_ch   = (int'(idx_q) == N_CH - 1);
        // The first sample after reset seeds every EMA directly.
        ema_new   = seeded_q ? ema_stepped : x_q;
        acc_next  = acc_q + ACC_W'(fxp_mul_shift(64'(w_sel), 64'(ema_new), FRAC));
        sat_w     = WIDTH'(fxp_sat(128'(acc_next), WIDTH));
        mag       = (sat_w < 0) ? -sat_w : sat_w;
        lim_eff   = limit_q[WIDTH-1] ? '0 : limit_q;
        over      = (mag > lim_eff);
    end

    // FSM: state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid) state_d = UPDATE;
            UPDATE:  if (last_ch)      state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs.
    always_comb begin
        bus.in_ready   = (state_q == IDLE);
        bus.out_valid  = (state_q == DONE);
        bus.out_signal = out_signal_q;
        bus.out_over   = out_over_q;
        bus.out_warm   = out_warm_q;
        risk_trip      = risk_trip_q;
    end

    // Datapath next-state.
    always_comb begin
        idx_d        = idx_q;
        ema_d        = ema_q;
        w_d          = w_q;
        x_d          = x_q;
        limit_d      = limit_q;
        acc_d        = acc_q;
        seeded_d     = seeded_q;
        count_d      = count_q;
        out_signal_d = out_signal_q;
        out_over_d   = out_over_q;
        out_warm_d   = out_warm_q;
        risk_trip_d  = risk_trip_q;

        if (risk_clr) begin
            risk_trip_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    x_d     = bus.in_sample;
                    limit_d = bus.limit;
                    for (int i = 0; i < N_CH; i++) begin
                        w_d[i] = bus.w_flat[i*WIDTH +: WIDTH];
                    end
                    idx_d = '0;
                    acc_d = '0;
                end
            end
            UPDATE: begin
                ema_d[idx_q] = ema_new;
                acc_d        = acc_next;
                idx_d        = idx_q + IDX_W'(1);
                if (last_ch) begin
                    seeded_d = 1'b1;
                    if (count_q < CNT_W'(WARM_SAMPLES)) begin
                        count_d = count_q + CNT_W'(1);
                    end
                    out_warm_d   = (count_d >= CNT_W'(WARM_SAMPLES));
                    out_signal_d = sat_w;
                    out_over_d   = over;
                    // A new trip overrides a clear in the same cycle.
                    if (over) begin
                        risk_trip_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q        <= '0;
            x_q          <= '0;
            limit_q      <= '0;
            acc_q        <= '0;
            seeded_q     <= 1'b0;
            count_q      <= '0;
            out_signal_q <= '0;
            out_over_q   <= 1'b0;
            out_warm_q   <= 1'b0;
            risk_trip_q  <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                ema_q[i] <= '0;
                w_q[i]   <= '0;
            end
        end else begin
            idx_q        <= idx_d;
            x_q          <= x_d;
            limit_q      <= limit_d;
            acc_q        <= acc_d;
            seeded_q     <= seeded_d;
            count_q      <= count_d;
            out_signal_q <= out_signal_d;
            out_over_q   <= out_over_d;
            out_warm_q   <= out_warm_d;
            risk_trip_q  <= risk_trip_d;
            ema_q        <= ema_d;
            w_q          <= w_d;
        end
    end
endmodule

// File: tb/tb_fxp_ema_signal_engine.sv
// -----------------------------------------------------------------------------
// tb_fxp_ema_signal_engine
//   Directed bench for fxp_ema_signal_engine (WIDTH=32, FRAC=16, N_CH=2,
//   shifts 5/7). Expected values are hand-computed Q16.16 constants.
// -----------------------------------------------------------------------------
module tb_fxp_ema_signal_engine;
    localparam int WIDTH = 32;
    localparam int N_CH  = 2;

    localparam logic [31:0] Q_0_25 = 32'h0000_4000;
    localparam logic [31:0] Q_0_75 = 32'h0000_C000;
    localparam logic [31:0] Q_1    = 32'h0001_0000;
    localparam logic [31:0] Q_2    = 32'h0002_0000;
    localparam logic [31:0] Q_3    = 32'h0003_0000;

    logic clk = 1'b0;
    logic rst_n;
    logic risk_clr;
    logic risk_trip;

    int total = 0;
    int bad   = 0;
    int lat;

    fxp_ema_signal_engine_if #(.WIDTH(WIDTH), .N_CH(N_CH)) bus ();

    fxp_ema_signal_engine #(
        .WIDTH(32), .FRAC(16), .N_CH(2),
        .SHIFT_BASE(5), .SHIFT_STEP(2), .WARM_SAMPLES(32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .risk_clr  (risk_clr),
        .risk_trip (risk_trip),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_w(input logic [31:0] w0, input logic [31:0] w1);
        bus.w_flat = {w1, w0};
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Present one sample for one edge, then wait (bounded) for the result.
    task automatic send(input logic [31:0] x, output int l);
        bus.in_sample = x;
        bus.in_valid  = 1'b1;
        tick();
        bus.in_valid  = 1'b0;
        l = 0;
        while (bus.out_valid !== 1'b1 && l < 20) begin
            tick();
            l++;
        end
    endtask

    task automatic pop();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chkb("pop_out_valid", bus.out_valid, 1'b0);
        chkb("pop_in_ready", bus.in_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_sample = '0;
        bus.w_flat    = '0;
        bus.limit     = Q_2;
        bus.out_ready = 1'b0;
        risk_clr      = 1'b0;
        do_reset();

        // Reset state.
        chkb("rst_in_ready", bus.in_ready, 1'b1);
        chkb("rst_out_valid", bus.out_valid, 1'b0);
        chk ("rst_signal", bus.out_signal, 32'd0);
        chkb("rst_over", bus.out_over, 1'b0);
        chkb("rst_warm", bus.out_warm, 1'b0);
        chkb("rst_trip", risk_trip, 1'b0);

        // Seed: x=1.0, w={0.75,0.25}.
        set_w(Q_0_75, Q_0_25);
        send(Q_1, lat);
        chk ("seed_lat", lat, 32'd2);
        chk ("seed_signal", bus.out_signal, 32'd65536);
        chkb("seed_over", bus.out_over, 1'b0);
        chkb("seed_trip", risk_trip, 1'b0);
        chkb("done_in_ready", bus.in_ready, 1'b0);
        pop();

        // Update: x=3.0 -> ema={69632,66560}.
        send(Q_3, lat);
        chk ("upd_lat", lat, 32'd2);
        chk ("upd_signal", bus.out_signal, 32'd68864);

        // Backpressure with an ignored sample offered meanwhile.
        bus.in_sample = 32'h0064_0000;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chkb("bp_out_valid", bus.out_valid, 1'b1);
            chk ("bp_signal", bus.out_signal, 32'd68864);
            chkb("bp_in_ready", bus.in_ready, 1'b0);
        end
        bus.in_valid = 1'b0;
        pop();

        // Second update proves the offered sample was not absorbed.
        send(Q_3, lat);
        chk ("upd2_signal", bus.out_signal, 32'd72094);
        pop();

        // Risk: w={2.0,2.0}, seed x=1.0.
        do_reset();
        set_w(Q_2, Q_2);
        send(Q_1, lat);
        chk ("risk_signal", bus.out_signal, 32'd262144);
        chkb("risk_over", bus.out_over, 1'b1);
        chkb("risk_trip", risk_trip, 1'b1);
        pop();
        chkb("risk_trip_hold", risk_trip, 1'b1);

        // Non-over result leaves the sticky flag set.
        set_w(Q_0_75, Q_0_25);
        send(Q_1, lat);
        chk ("nover_signal", bus.out_signal, 32'd65536);
        chkb("nover_over", bus.out_over, 1'b0);
        chkb("nover_trip_sticky", risk_trip, 1'b1);
        pop();

        // Clear pulse.
        risk_clr = 1'b1;
        tick();
        risk_clr = 1'b0;
        chkb("clr_trip", risk_trip, 1'b0);

        // Clear held across a new over result: the trip wins.
        set_w(Q_2, Q_2);
        risk_clr = 1'b1;
        send(Q_1, lat);
        chk ("clrset_signal", bus.out_signal, 32'd262144);
        chkb("clrset_trip", risk_trip, 1'b1);
        risk_clr = 1'b0;
        pop();

        // Negative limit acts as zero.
        bus.limit = 32'hFFFF_FFFF;
        set_w(Q_0_75, Q_0_25);
        send(Q_1, lat);
        chk ("neglim_signal", bus.out_signal, 32'd65536);
        chkb("neglim_over", bus.out_over, 1'b1);
        pop();
        bus.limit = Q_2;

        // Positive saturation.
        do_reset();
        set_w(32'h7FFF_FFFF, 32'h7FFF_FFFF);
        send(32'h7FFF_0000, lat);
        chk ("satp_signal", bus.out_signal, 32'h7FFF_FFFF);
        chkb("satp_over", bus.out_over, 1'b1);
        pop();

        // Negative saturation is symmetric.
        do_reset();
        send(32'h8000_0000, lat);
        chk ("satn_signal", bus.out_signal, 32'h8000_0001);
        chkb("satn_over", bus.out_over, 1'b1);
        pop();

        // Reset in the middle of UPDATE.
        set_w(Q_0_75, Q_0_25);
        bus.in_sample = Q_1;
        bus.in_valid  = 1'b1;
        tick();
        bus.in_valid  = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chkb("mid_in_ready", bus.in_ready, 1'b1);
        chkb("mid_out_valid", bus.out_valid, 1'b0);
        chk ("mid_signal", bus.out_signal, 32'd0);
        chkb("mid_trip", risk_trip, 1'b0);

        // Re-seed, then count to warm-up.
        send(Q_3, lat);
        chk ("reseed_signal", bus.out_signal, 32'd196608);
        chkb("reseed_warm", bus.out_warm, 1'b0);
        pop();
        for (int n = 2; n <= 31; n++) begin
            send(Q_3, lat);
            chk ("warm_lat", lat, 32'd2);
            chkb("warm_pre", bus.out_warm, 1'b0);
            pop();
        end
        send(Q_3, lat);
        chkb("warm_32", bus.out_warm, 1'b1);
        chk ("warm_signal", bus.out_signal, 32'd196608);
        pop();
        send(Q_3, lat);
        chkb("warm_33", bus.out_warm, 1'b1);
        pop();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
